// File: rtl/d2_mul_acc_if.sv
// Handshake/bus bundle for one d2_mul_acc neuron: command, input beat stream,
// and result stream. The master drives commands/beats and consumes results.
interface d2_mul_acc_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
);
  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic [DATA_W-1:0] bias_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] x_i;
  logic [DATA_W-1:0] w_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] y_o;
  logic              sat_o;
  logic              busy_o;

  modport master (
    output start_i, len_i, bias_i, in_valid_i, x_i, w_i, out_ready_i,
    input  in_ready_o, out_valid_o, y_o, sat_o, busy_o
  );

  modport slave (
    input  start_i, len_i, bias_i, in_valid_i, x_i, w_i, out_ready_i,
    output in_ready_o, out_valid_o, y_o, sat_o, busy_o
  );
endinterface

// File: rtl/d2_mul_acc.sv
// Pipelined fixed-point dot-product neuron: product register, guard-bit
// accumulator, then bias add, round half up, arithmetic shift and saturate.
module d2_mul_acc #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int LEN_W   = 10,
  parameter int GUARD_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  d2_mul_acc_if.slave    bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + GUARD_W;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

  state_t                    state, state_nxt;
  logic [LEN_W-1:0]          len_q;
  logic [DATA_W-1:0]         bias_q;
  logic [LEN_W-1:0]          count;
  logic [LEN_W-1:0]          count_nxt;
  logic signed [PROD_W-1:0]  prod_q;
  logic                      prod_vld;
  logic signed [ACC_W-1:0]   acc;
  logic                      drain_cnt;
  logic [DATA_W-1:0]         y_q;
  logic                      sat_q;

  logic                      room;
  logic                      accept;
  logic                      drain_done;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   rounded;
  logic signed [ACC_W-1:0]   shifted;
  logic [DATA_W-1:0]         y_fin;
  logic                      sat_fin;

  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) <<< (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  assign room       = (count < len_q);
  assign accept     = (state == ACC) && bus.in_valid_i && room;
  assign count_nxt  = count + LEN_W'(accept);
  assign drain_done = (state == DRAIN) && drain_cnt;

  // Final step on the fully drained accumulator: bias aligned to the
  // product's binary point, +half LSB, floor shift, clip to DATA_W.
  always_comb begin
    bias_ext = ACC_W'($signed(bias_q));
    rounded  = acc + (bias_ext <<< FRAC_W) + HALF;
    shifted  = rounded >>> FRAC_W;
    y_fin    = shifted[DATA_W-1:0];
    sat_fin  = 1'b0;
    if (shifted > Y_MAX) begin
      y_fin   = Y_MAX[DATA_W-1:0];
      sat_fin = 1'b1;
    end else if (shifted < Y_MIN) begin
      y_fin   = Y_MIN[DATA_W-1:0];
      sat_fin = 1'b1;
    end
  end

  // Next-state logic; ACC exits as soon as the last needed beat is taken
  // (or immediately for a zero-length vector) so DRAIN flushes both stages.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start_i) state_nxt = ACC;
      ACC:   if (count_nxt == len_q) state_nxt = DRAIN;
      DRAIN: if (drain_cnt) state_nxt = OUT;
      OUT:   if (bus.out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Command latch, beat counter and drain timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      bias_q    <= '0;
      count     <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (state == IDLE && bus.start_i) begin
        len_q  <= bus.len_i;
        bias_q <= bus.bias_i;
        count  <= '0;
      end else begin
        count <= count_nxt;
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Stage 1: full-width signed product of the accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) prod_q <= $signed(bus.x_i) * $signed(bus.w_i);
    end
  end

  // Stage 2: guard-bit accumulator, cleared on every new start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (state == IDLE && bus.start_i) begin
      acc <= '0;
    end else if (prod_vld) begin
      acc <= acc + ACC_W'(prod_q);
    end
  end

  // Result register, loaded once at the end of DRAIN and held through OUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= '0;
      sat_q <= 1'b0;
    end else if (drain_done) begin
      y_q   <= y_fin;
      sat_q <= sat_fin;
    end
  end

  assign bus.in_ready_o  = (state == ACC) && room;
  assign bus.out_valid_o = (state == OUT);
  assign bus.busy_o      = (state != IDLE);
  assign bus.y_o         = y_q;
  assign bus.sat_o       = sat_q;
endmodule

// File: tb/tb_d2_mul_acc.sv
// Scoreboard bench for d2_mul_acc: driver pushes hand-computed results,
// monitor pops and compares when the DUT presents an output.
module tb_d2_mul_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  d2_mul_acc_if #(.DATA_W(16), .LEN_W(10)) bus ();
  d2_mul_acc #(.DATA_W(16), .FRAC_W(8), .LEN_W(10), .GUARD_W(8))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct { logic [15:0] y; logic sat; } exp_t;
  exp_t exp_q[$];

  logic [15:0] bx [8];
  logic [15:0] bw [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency reference points, result compare, hold stability.
  int   start_cyc = 0, beat_cyc = 0, mlen = 0;
  logic prev_v = 0, prev_r = 0, prev_s = 0;
  logic [15:0] prev_y = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start_i && !bus.busy_o) begin
        start_cyc = cyc;
        mlen = int'(bus.len_i);
      end
      if (bus.in_valid_i && bus.in_ready_o) beat_cyc = cyc;
      if (bus.out_valid_o && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(bus.out_valid_o), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("y", 32'(bus.y_o), 32'(e.y));
          chk("sat", 32'(bus.sat_o), 32'(e.sat));
          chk("latency", cyc, (mlen == 0) ? start_cyc + 4 : beat_cyc + 3);
        end
      end
      if (bus.out_valid_o && prev_v && !prev_r) begin
        chk("hold_y", 32'(bus.y_o), 32'(prev_y));
        chk("hold_sat", 32'(bus.sat_o), 32'(prev_s));
      end
    end
    prev_v = bus.out_valid_o && rst_n;
    prev_r = bus.out_ready_i;
    prev_y = bus.y_o;
    prev_s = bus.sat_o;
  end

  // Watchdog.
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input int len, input logic [15:0] bias,
                          input logic [15:0] ey, input logic es, input bit push);
    exp_t e;
    if (push) begin
      e.y = ey; e.sat = es;
      exp_q.push_back(e);
    end
    bus.start_i = 1'b1;
    bus.len_i   = 10'(len);
    bus.bias_i  = bias;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle);
    int i = 0;
    int guard = 0;
    bit v = 1'b1;
    bit took;
    while (i < n && guard < 200) begin
      bus.in_valid_i = v;
      bus.x_i = v ? bx[i] : 16'h7FFF;
      bus.w_i = v ? bw[i] : 16'h7FFF;
      took = v && bus.in_ready_o;
      @(negedge clk);
      if (took) i++;
      if (toggle) v = ~v;
      guard++;
    end
    if (i < n) chk("feed_timeout", i, n);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (bus.busy_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("idle_timeout", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
  endtask

  task automatic run(input int len, input logic [15:0] bias,
                     input logic [15:0] ey, input logic es);
    do_start(len, bias, ey, es, 1'b1);
    feed(len, 1'b0);
    wait_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
    chk({tag, "_y"}, 32'(bus.y_o), 32'd0);
    chk({tag, "_sat"}, 32'(bus.sat_o), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    int g;
    bus.start_i = 0; bus.len_i = 0; bus.bias_i = 0;
    bus.in_valid_i = 0; bus.x_i = 0; bus.w_i = 0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dot: 1*1 + 2*0.5 + (-1)*2 + bias 0.5 = 0.5
    bx[0] = 16'h0100; bw[0] = 16'h0100;
    bx[1] = 16'h0200; bw[1] = 16'h0080;
    bx[2] = 16'hFF00; bw[2] = 16'h0200;
    run(3, 16'h0080, 16'h0080, 1'b0);

    // Rounding: 0x80 raw -> half LSB rounds up; 0x7F rounds down.
    bx[0] = 16'h0001; bw[0] = 16'h0080;
    run(1, 16'h0000, 16'h0001, 1'b0);
    bw[0] = 16'h007F;
    run(1, 16'h0000, 16'h0000, 1'b0);

    // Saturation both directions.
    bx[0] = 16'h7FFF; bw[0] = 16'h7FFF;
    bx[1] = 16'h7FFF; bw[1] = 16'h7FFF;
    run(2, 16'h0000, 16'h7FFF, 1'b1);
    bx[0] = 16'h8000; bw[0] = 16'h7FFF;
    run(1, 16'h0000, 16'h8000, 1'b1);

    // Handshake: gapped input, stalled output, ignored start during OUT.
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bx[i] = 16'h0100;
      bw[i] = 16'(16'h0100 * (i + 1));
    end
    do_start(4, 16'h0000, 16'h0A00, 1'b0, 1'b1);
    feed(4, 1'b1);
    chk("hs_in_ready_done", 32'(bus.in_ready_o), 32'd0);
    g = 0;
    while (!bus.out_valid_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("hs_out_valid", 32'(bus.out_valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.start_i = (i == 1);
      bus.len_i   = 10'd1;
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    chk("hs_still_valid", 32'(bus.out_valid_o), 32'd1);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("hs_valid_drop", 32'(bus.out_valid_o), 32'd0);
    chk("hs_idle", 32'(bus.busy_o), 32'd0);
    repeat (3) @(negedge clk);
    chk("hs_start_ignored", 32'(bus.busy_o), 32'd0);

    // Zero length: result is just the rounded bias (-1.5).
    do_start(0, 16'hFE80, 16'hFE80, 1'b0, 1'b1);
    chk("zero_no_ready", 32'(bus.in_ready_o), 32'd0);
    wait_idle();

    // Reset mid-operation, then a clean run.
    bx[0] = 16'h4000; bw[0] = 16'h4000;
    bx[1] = 16'h4000; bw[1] = 16'h4000;
    do_start(5, 16'h0000, 16'h0000, 1'b0, 1'b0);
    feed(2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    bx[0] = 16'h0100; bw[0] = 16'h0300;
    run(1, 16'h0000, 16'h0300, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
